// File: rtl/cmd_ram_burst.sv
// cmd_ram_burst: command-driven single-port RAM with burst auto-increment and protocol error tracking
module cmd_ram_burst #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 8,
  parameter int MEM_DEPTH     = 256,
  parameter int AUTO_INC      = 1,
  parameter int ERR_CNT_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx_valid,
  input  logic [DATA_WIDTH+1:0]    din,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     tx_valid,
  output logic                     proto_err,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr, ld_addr;
  logic [DATA_WIDTH-1:0] payload;
  logic [1:0]            op;
  logic                  wr_vld, rd_vld, in_range;
  logic                  cmd_wa, cmd_wd, cmd_ra, cmd_rd, wd_ok, rd_ok, reject;

  function automatic logic [ADDR_WIDTH-1:0] nxt(input logic [ADDR_WIDTH-1:0] a);
    return (a == ADDR_WIDTH'(MEM_DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  // decode the command and decide whether it is accepted
  always_comb begin
    op       = din[DATA_WIDTH+1:DATA_WIDTH];
    payload  = din[DATA_WIDTH-1:0];
    ld_addr  = payload[ADDR_WIDTH-1:0];
    in_range = 32'(ld_addr) < MEM_DEPTH;
    cmd_wa   = rx_valid && op == 2'b00;
    cmd_wd   = rx_valid && op == 2'b01;
    cmd_ra   = rx_valid && op == 2'b10;
    cmd_rd   = rx_valid && op == 2'b11;
    wd_ok    = cmd_wd && wr_vld;
    rd_ok    = cmd_rd && rd_vld;
    reject   = ((cmd_wa || cmd_ra) && !in_range) || (cmd_wd && !wr_vld) || (cmd_rd && !rd_vld);
  end

  // memory array is never reset; contents are undefined until written
  always_ff @(posedge clk)
    if (wd_ok) mem[wr_addr] <= payload;

  // address channels, registered read port and error reporting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout      <= '0;
      tx_valid  <= 1'b0;
      proto_err <= 1'b0;
      err_count <= '0;
      wr_addr   <= '0;
      rd_addr   <= '0;
      wr_vld    <= 1'b0;
      rd_vld    <= 1'b0;
    end else begin
      tx_valid  <= rd_ok;
      proto_err <= reject;
      if (rd_ok) dout <= mem[rd_addr];
      if (reject && err_count != '1) err_count <= err_count + 1'b1;
      if (cmd_wa) wr_vld <= in_range;
      if (cmd_wa && in_range) wr_addr <= ld_addr;
      else if (wd_ok && AUTO_INC != 0) wr_addr <= nxt(wr_addr);
      if (cmd_ra) rd_vld <= in_range;
      if (cmd_ra && in_range) rd_addr <= ld_addr;
      else if (rd_ok && AUTO_INC != 0) rd_addr <= nxt(rd_addr);
    end
  end
endmodule
